sensor_frontend: RTL and testbench

Conditions raw sensor and keypad signals into the clean decision inputs `pir`, `isDark`, `tempHigh` and `authorized` consumed by the home-automation decision logic. It sits between the board I/O / ADC sampler and the controller.
- PIR input: synchronised and debounced, with a hold-on time.
- Light and temperature samples: hysteresis thresholds.
- Keypad: PIN-entry state machine with a failure lockout and a timed authorisation window.

---
 rtl/sensor_frontend.sv | 182 ++++++++++++++++++
 tb/tb_sensor_frontend.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frontend.sv
// Sensor front end: PIR synchroniser/debounce/hold, light and temperature
// hysteresis flags, and a keypad PIN state machine with lockout and timed authorisation.
module sensor_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PIR_HOLD_CYCLES = 1000,
    parameter logic [7:0]  DARK_ON         = 8'd60,
    parameter logic [7:0]  DARK_OFF        = 8'd80,
    parameter logic [7:0]  TEMP_ON         = 8'd150,
    parameter logic [7:0]  TEMP_OFF        = 8'd140,
    parameter logic [15:0] CODE            = 16'h1234,
    parameter int unsigned MAX_FAILS       = 3,
    parameter int unsigned ENTRY_TIMEOUT   = 5000,
    parameter int unsigned AUTH_CYCLES     = 50000,
    parameter int unsigned LOCKOUT_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pirRaw,
    input  logic       sampleValid,
    input  logic [7:0] lightSample,
    input  logic [7:0] tempSample,
    input  logic       keyValid,
    input  logic [3:0] keyDigit,
    output logic       pir,
    output logic       isDark,
    output logic       tempHigh,
    output logic       authorized,
    output logic       lockout
);

    localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W    = $clog2(PIR_HOLD_CYCLES + 1);
    localparam int unsigned FAIL_W    = $clog2(MAX_FAILS + 1);
    localparam int unsigned TMAX_A    = (AUTH_CYCLES > ENTRY_TIMEOUT) ? AUTH_CYCLES : ENTRY_TIMEOUT;
    localparam int unsigned TIMER_MAX = (LOCKOUT_CYCLES > TMAX_A) ? LOCKOUT_CYCLES : TMAX_A;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(PIR_HOLD_CYCLES);
    localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);
    localparam logic [TIMER_W-1:0] ENTRY_LAST = TIMER_W'(ENTRY_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] AUTH_LAST  = TIMER_W'(AUTH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCKOUT_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ENTRY   = 2'd1;
    localparam logic [1:0] GRANTED = 2'd2;
    localparam logic [1:0] LOCKED  = 2'd3;

    logic              pirMeta;
    logic              pirSync;
    logic              pirDeb;
    logic [DEB_W-1:0]  debCnt;
    logic [HOLD_W-1:0] holdCnt;

    // PIR: two-flop synchroniser, mismatch-count debounce, then hold-on stretch
    always_ff @(posedge clk) begin
        if (rst) begin
            pirMeta <= 1'b0;
            pirSync <= 1'b0;
            pirDeb  <= 1'b0;
            debCnt  <= '0;
            holdCnt <= '0;
        end else begin
            pirMeta <= pirRaw;
            pirSync <= pirMeta;
            if (pirSync == pirDeb) begin
                debCnt <= '0;
            end else if (debCnt == DEB_LAST) begin
                pirDeb <= pirSync;
                debCnt <= '0;
            end else begin
                debCnt <= debCnt + 1'b1;
            end
            if (pirDeb) begin
                holdCnt <= HOLD_LOAD;
            end else if (holdCnt != '0) begin
                holdCnt <= holdCnt - 1'b1;
            end
        end
    end

    assign pir = pirDeb | (holdCnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            isDark   <= 1'b0;
            tempHigh <= 1'b0;
        end else if (sampleValid) begin
            if (lightSample < DARK_ON) begin
                isDark <= 1'b1;
            end else if (lightSample > DARK_OFF) begin
                isDark <= 1'b0;
            end
            if (tempSample >= TEMP_ON) begin
                tempHigh <= 1'b1;
            end else if (tempSample <= TEMP_OFF) begin
                tempHigh <= 1'b0;
            end
        end
    end

    logic [1:0]         state;
    logic [11:0]        digits;
    logic [1:0]         digitCnt;
    logic [FAIL_W-1:0]  fails;
    logic [TIMER_W-1:0] timer;
    logic               isDigit;
    logic               isClear;
    logic [15:0]        entered;

    assign isDigit = keyValid && (keyDigit <= 4'd9);
    assign isClear = keyValid && (keyDigit == 4'hA);
    // Only the first three digits are stored; the fourth is compared straight off the keypad
    assign entered = {digits, keyDigit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            digits   <= '0;
            digitCnt <= '0;
            fails    <= '0;
            timer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (isDigit) begin
                        digits   <= {8'h00, keyDigit};
                        digitCnt <= 2'd1;
                        timer    <= '0;
                        state    <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (isDigit) begin
                        timer <= '0;
                        if (digitCnt == 2'd3) begin
                            digitCnt <= '0;
                            if (entered == CODE) begin
                                state <= GRANTED;
                                fails <= '0;
                            end else if (fails == FAIL_LAST) begin
                                state <= LOCKED;
                                fails <= '0;
                            end else begin
                                state <= IDLE;
                                fails <= fails + 1'b1;
                            end
                        end else begin
                            digits   <= {digits[7:0], keyDigit};
                            digitCnt <= digitCnt + 1'b1;
                        end
                    end else if (isClear || (timer == ENTRY_LAST)) begin
                        state    <= IDLE;
                        digitCnt <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GRANTED: begin
                    if (isClear || (timer == AUTH_LAST)) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOCKED: begin
                    if (timer == LOCK_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign authorized = (state == GRANTED);
    assign lockout    = (state == LOCKED);

endmodule

// File: tb/tb_sensor_frontend.sv
// Bench for sensor_frontend: directed test-plan sequences plus randomized traffic,
// all compared against an edge-count based behavioural model.
module tb_sensor_frontend;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int ETO  = 15;
    localparam int AUTH = 20;
    localparam int LOCK = 30;
    localparam int MAXF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pirRaw = 1'b0;
    logic       sampleValid = 1'b0;
    logic [7:0] lightSample = 8'd0;
    logic [7:0] tempSample = 8'd0;
    logic       keyValid = 1'b0;
    logic [3:0] keyDigit = 4'd0;
    logic       pir, isDark, tempHigh, authorized, lockout;

    always #5 clk = ~clk;

    sensor_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .PIR_HOLD_CYCLES(HOLD),
        .MAX_FAILS(MAXF),
        .ENTRY_TIMEOUT(ETO),
        .AUTH_CYCLES(AUTH),
        .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pirRaw(pirRaw),
        .sampleValid(sampleValid),
        .lightSample(lightSample),
        .tempSample(tempSample),
        .keyValid(keyValid),
        .keyDigit(keyDigit),
        .pir(pir),
        .isDark(isDark),
        .tempHigh(tempHigh),
        .authorized(authorized),
        .lockout(lockout)
    );

    int checks = 0;
    int failures = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: event times measured in edge numbers
    int  mCyc = 0;
    int  lastFlip = 0;
    int  lastLoad = -100;
    bit  mD = 1'b0;
    bit  mDark = 1'b0;
    bit  mTemp = 1'b0;
    int  mode = 0;
    int  mFails = 0;
    int  deadline = 0;
    int  digQ[$];
    bit  rawQ[$];

    always @(posedge clk) begin
        bit flip;
        int pin;
        mCyc++;
        if (rst) begin
            rawQ.delete();
            for (int i = 0; i < DEB + 2; i++) rawQ.push_front(1'b0);
            mD = 1'b0;
            lastFlip = mCyc;
            lastLoad = mCyc - HOLD;
            mDark = 1'b0;
            mTemp = 1'b0;
            mode = 0;
            mFails = 0;
            digQ.delete();
        end else begin
            rawQ.push_front(pirRaw);
            if (rawQ.size() > DEB + 2) void'(rawQ.pop_back());
            // rawQ[k] is pirRaw as sampled k edges ago; the synchroniser adds two edges
            flip = (mCyc - lastFlip >= DEB);
            for (int k = 0; k < DEB; k++) if (rawQ[2 + k] == mD) flip = 1'b0;
            if (mD) lastLoad = mCyc;
            if (flip) begin
                mD = !mD;
                lastFlip = mCyc;
            end

            if (sampleValid) begin
                if (lightSample < 60) mDark = 1'b1;
                else if (lightSample > 80) mDark = 1'b0;
                if (tempSample >= 150) mTemp = 1'b1;
                else if (tempSample <= 140) mTemp = 1'b0;
            end

            case (mode)
                0: if (keyValid && keyDigit <= 9) begin
                    digQ.delete();
                    digQ.push_back(int'(keyDigit));
                    deadline = mCyc + ETO;
                    mode = 1;
                end
                1: if (keyValid && keyDigit <= 9) begin
                    digQ.push_back(int'(keyDigit));
                    deadline = mCyc + ETO;
                    if (digQ.size() == 4) begin
                        pin = digQ[0] * 1000 + digQ[1] * 100 + digQ[2] * 10 + digQ[3];
                        if (pin == 1234) begin
                            mode = 2; mFails = 0; deadline = mCyc + AUTH;
                        end else if (mFails + 1 == MAXF) begin
                            mode = 3; mFails = 0; deadline = mCyc + LOCK;
                        end else begin
                            mode = 0; mFails++;
                        end
                    end
                end else if ((keyValid && keyDigit == 4'hA) || mCyc == deadline) begin
                    mode = 0;
                end
                2: if ((keyValid && keyDigit == 4'hA) || mCyc == deadline) mode = 0;
                3: if (mCyc == deadline) mode = 0;
                default: mode = 0;
            endcase
        end
    end

    bit checkEn = 1'b0;

    always @(negedge clk) begin
        if (checkEn) begin
            checkVal("pir", pir, 32'(mD || (mCyc - lastLoad < HOLD)));
            checkVal("isDark", isDark, 32'(mDark));
            checkVal("tempHigh", tempHigh, 32'(mTemp));
            checkVal("authorized", authorized, 32'(mode == 2));
            checkVal("lockout", lockout, 32'(mode == 3));
        end
    end

    task automatic pressKey(input logic [3:0] k);
        keyDigit = k;
        keyValid = 1'b1;
        @(negedge clk);
        keyValid = 1'b0;
    endtask

    task automatic enterCode(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) pressKey(c[i*4 +: 4]);
    endtask

    task automatic sample(input logic [7:0] l, input logic [7:0] t);
        lightSample = l;
        tempSample = t;
        sampleValid = 1'b1;
        @(negedge clk);
        sampleValid = 1'b0;
    endtask

    logic [7:0] lights [5] = '{8'd90, 8'd59, 8'd70, 8'd80, 8'd81};
    logic       darks  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] temps  [5] = '{8'd149, 8'd150, 8'd141, 8'd140, 8'd140};
    logic       highs  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int kp;
        int ptr;
        kp = 0;
        ptr = 0;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkVal("rstPir", pir, 0);
        checkVal("rstDark", isDark, 0);
        checkVal("rstTemp", tempHigh, 0);
        checkVal("rstAuth", authorized, 0);
        checkVal("rstLock", lockout, 0);
        rst = 1'b0;

        // Short PIR pulse is filtered, long one rises at E0+5 and holds 10 edges after the fall
        pirRaw = 1'b1;
        repeat (3) @(negedge clk);
        pirRaw = 1'b0;
        repeat (12) @(negedge clk);
        checkVal("pulsePir", pir, 0);
        pirRaw = 1'b1;
        repeat (5) @(negedge clk);
        checkVal("pirRiseEarly", pir, 0);
        @(negedge clk);
        checkVal("pirRise", pir, 1);
        repeat (14) @(negedge clk);
        pirRaw = 1'b0;
        repeat (15) @(negedge clk);
        checkVal("pirHoldLast", pir, 1);
        @(negedge clk);
        checkVal("pirFall", pir, 0);

        for (int i = 0; i < 5; i++) begin
            sample(lights[i], temps[i]);
            checkVal("hystDark", isDark, 32'(darks[i]));
            checkVal("hystTemp", tempHigh, 32'(highs[i]));
        end
        lightSample = 8'd10;
        tempSample = 8'd200;
        repeat (3) @(negedge clk);
        checkVal("noValidDark", isDark, 0);
        checkVal("noValidTemp", tempHigh, 0);

        enterCode(16'h1234);
        checkVal("authOn", authorized, 1);
        repeat (19) @(negedge clk);
        checkVal("authLast", authorized, 1);
        @(negedge clk);
        checkVal("authOff", authorized, 0);
        enterCode(16'h1234);
        repeat (5) @(negedge clk);
        pressKey(4'hA);
        checkVal("authLogout", authorized, 0);

        // Three wrong PINs lock out; keys during lockout are ignored
        enterCode(16'h1111);
        enterCode(16'h1111);
        checkVal("lockNotYet", lockout, 0);
        enterCode(16'h1111);
        checkVal("lockOn", lockout, 1);
        enterCode(16'h1234);
        checkVal("lockIgnoreAuth", authorized, 0);
        repeat (25) @(negedge clk);
        checkVal("lockLast", lockout, 1);
        @(negedge clk);
        checkVal("lockOff", lockout, 0);
        enterCode(16'h1234);
        checkVal("authAfterLock", authorized, 1);
        pressKey(4'hA);

        // Timeout abandons entry without counting a failure
        enterCode(16'h1111);
        enterCode(16'h1111);
        pressKey(4'h1);
        pressKey(4'h2);
        repeat (15) @(negedge clk);
        checkVal("timeoutNoLock", lockout, 0);
        enterCode(16'h1111);
        checkVal("failsKept", lockout, 1);
        repeat (30) @(negedge clk);
        pressKey(4'h1);
        pressKey(4'h2);
        repeat (15) @(negedge clk);
        enterCode(16'h1234);
        checkVal("authAfterTimeout", authorized, 1);
        pressKey(4'hA);
        pressKey(4'h1);
        pressKey(4'hA);
        enterCode(16'h1234);
        checkVal("authAfterClear", authorized, 1);
        pressKey(4'hA);

        // Reset mid-entry discards digits and fail count
        enterCode(16'h1111);
        enterCode(16'h1111);
        pressKey(4'h1);
        pressKey(4'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("midRstAuth", authorized, 0);
        checkVal("midRstLock", lockout, 0);
        checkVal("midRstPir", pir, 0);
        enterCode(16'h1111);
        checkVal("midRstNoLock", lockout, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) kp = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) pirRaw = ~pirRaw;
            sampleValid = ($urandom_range(0, 3) == 0);
            lightSample = 8'($urandom_range(40, 100));
            tempSample = 8'($urandom_range(130, 160));
            keyValid = ($urandom_range(0, 9) < kp);
            if (keyValid && $urandom_range(0, 3) != 0) begin
                keyDigit = 4'(ptr + 1);
                ptr = (ptr + 1) % 4;
            end else begin
                keyDigit = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        keyValid = 1'b0;
        sampleValid = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
